// File: rtl/audio_pkg.sv
// Shared audio definitions: I2S word-select levels, capture FSM encoding, default sample width.
package audio_pkg;

    localparam int   DEFAULT_DATA_WIDTH = 24;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } cap_state_t;

endpackage

// File: rtl/i2s_rx_frame_capture_if.sv
// Stereo frame valid/ready port between the I2S capture block and its consumer.
interface i2s_rx_frame_capture_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] m_left;
    logic [DATA_WIDTH-1:0] m_right;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_left,
        output m_right,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_left,
        input  m_right,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/i2s_pin_sync.sv
// Brings the raw I2S pins into the ACLK domain and strobes bstb once per BCLK rising edge.
// Latency 3 ACLK from raw pin to bstb/lr_s/sd_s; no backpressure.
module i2s_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    input  logic lrclk,
    input  logic sdata,
    output logic bstb,
    output logic lr_s,
    output logic sd_s
);

    logic bclk_meta, bclk_sync, bclk_prev;
    logic lr_meta, lr_sync;
    logic sd_meta, sd_sync;

    // lr/sd get one extra stage so they line up with the registered edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_prev <= 1'b0;
            bstb      <= 1'b0;
            lr_meta   <= 1'b0;
            lr_sync   <= 1'b0;
            lr_s      <= 1'b0;
            sd_meta   <= 1'b0;
            sd_sync   <= 1'b0;
            sd_s      <= 1'b0;
        end else begin
            bclk_meta <= bclk;
            bclk_sync <= bclk_meta;
            bclk_prev <= bclk_sync;
            bstb      <= bclk_sync & ~bclk_prev;
            lr_meta   <= lrclk;
            lr_sync   <= lr_meta;
            lr_s      <= lr_sync;
            sd_meta   <= sdata;
            sd_sync   <= sd_meta;
            sd_s      <= sd_sync;
        end
    end

endmodule

// File: rtl/i2s_rx_frame_capture.sv
// Deserialises an oversampled I2S stream into left/right frames on a valid/ready port.
// m_valid rises 4 ACLK after raw BCLK is seen high at the committing slot start; a frame arriving while one is held unaccepted is dropped and sets overrun.
module i2s_rx_frame_capture
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   enable,
    input  logic                   i2s_bclk,
    input  logic                   i2s_lrclk,
    input  logic                   i2s_sdata,
    i2s_rx_frame_capture_if.master frame,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    logic                  bstb, lr_s, sd_s;
    logic                  lr_prev, slot_start;
    logic [BW-1:0]         bit_cnt, bit_idx;
    logic [DATA_WIDTH-1:0] word, left_hold;
    logic [DATA_WIDTH-1:0] out_left, out_right;
    logic                  out_valid;
    logic                  latch_left, commit;
    cap_state_t            state, state_nxt;

    i2s_pin_sync u_pin_sync (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .bclk  (i2s_bclk),
        .lrclk (i2s_lrclk),
        .sdata (i2s_sdata),
        .bstb  (bstb),
        .lr_s  (lr_s),
        .sd_s  (sd_s)
    );

    assign slot_start = bstb && (lr_s != lr_prev);
    assign bit_idx    = BW'(DATA_WIDTH - 1) - bit_cnt;

    // The slot-start bit is the I2S one-bit delay, so capture begins on the next strobe
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lr_prev   <= 1'b0;
            bit_cnt   <= '0;
            word      <= '0;
            left_hold <= '0;
        end else begin
            if (bstb)
                lr_prev <= lr_s;
            if (!enable) begin
                bit_cnt   <= '0;
                word      <= '0;
                left_hold <= '0;
            end else begin
                if (latch_left)
                    left_hold <= word;
                if (slot_start) begin
                    bit_cnt <= '0;
                    word    <= '0;
                end else if (bstb && (bit_cnt < BW'(DATA_WIDTH))) begin
                    word[bit_idx] <= sd_s;
                    bit_cnt       <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        latch_left = 1'b0;
        commit     = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else if (slot_start) begin
            case (state)
                IDLE: begin
                    if (lr_s == I2S_LEFT)
                        state_nxt = LEFT;
                end
                LEFT: begin
                    if (lr_s == I2S_RIGHT) begin
                        latch_left = 1'b1;
                        state_nxt  = RIGHT;
                    end
                end
                RIGHT: begin
                    if (lr_s == I2S_LEFT) begin
                        commit    = 1'b1;
                        state_nxt = LEFT;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Held frame is only replaced when the consumer has taken (or is taking) it
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_left    <= '0;
            out_right   <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (commit && (!out_valid || frame.m_ready)) begin
                out_left    <= left_hold;
                out_right   <= word;
                out_valid   <= 1'b1;
                frame_count <= frame_count + 1'b1;
            end else if (out_valid && frame.m_ready) begin
                out_valid <= 1'b0;
            end

            if (commit && out_valid && !frame.m_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign frame.m_left  = out_left;
    assign frame.m_right = out_right;
    assign frame.m_valid = out_valid;

endmodule

// File: tb/tb_i2s_rx_frame_capture.sv
// Directed bench for i2s_rx_frame_capture: drives I2S slots bit by bit and checks held frames.
module tb_i2s_rx_frame_capture;
    import audio_pkg::*;

    localparam int BCLK_HALF = 163;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b0;
    logic        bclk = 1'b1;
    logic        lrclk = 1'b0;
    logic        sdata = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        overrun;
    logic [31:0] frame_count;

    int n_checks = 0;
    int n_pass   = 0;

    i2s_rx_frame_capture_if #(.DATA_WIDTH(24)) frame_bus ();

    i2s_rx_frame_capture #(.DATA_WIDTH(24), .CNT_WIDTH(32)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .enable      (enable),
        .i2s_bclk    (bclk),
        .i2s_lrclk   (lrclk),
        .i2s_sdata   (sdata),
        .frame       (frame_bus),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .frame_count (frame_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    // One delay bit, then nbits data bits MSB-first taken from data[23] downwards
    task automatic send_slot(input logic lr, input logic [23:0] data, input int nbits);
        logic [23:0] sh;
        sh = data;
        for (int i = 0; i <= nbits; i++) begin
            bclk  = 1'b0;
            lrclk = lr;
            if (i == 0) begin
                sdata = 1'b0;
            end else begin
                sdata = sh[23];
                sh    = sh << 1;
            end
            #BCLK_HALF;
            bclk = 1'b1;
            #BCLK_HALF;
        end
    endtask

    task automatic pulse_ready();
        @(posedge ACLK); #1;
        frame_bus.m_ready = 1'b1;
        @(posedge ACLK); #1;
        frame_bus.m_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge ACLK); #1;
        overrun_clr = 1'b1;
        @(posedge ACLK); #1;
        overrun_clr = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [23:0] l, input logic [23:0] r,
                               input logic [31:0] cnt);
        check({tag, " valid"}, {31'd0, frame_bus.m_valid}, 32'd1);
        check({tag, " left"},  {8'd0, frame_bus.m_left},   {8'd0, l});
        check({tag, " right"}, {8'd0, frame_bus.m_right},  {8'd0, r});
        check({tag, " count"}, frame_count, cnt);
    endtask

    initial begin
        frame_bus.m_ready = 1'b0;

        // reset state
        wait_clks(2);
        check("rst valid",   {31'd0, frame_bus.m_valid}, 32'd0);
        check("rst left",    {8'd0, frame_bus.m_left},   32'd0);
        check("rst right",   {8'd0, frame_bus.m_right},  32'd0);
        check("rst overrun", {31'd0, overrun},           32'd0);
        check("rst count",   frame_count,                32'd0);
        ARESETN = 1'b1;
        enable  = 1'b1;
        wait_clks(2);

        // basic 32-bit slot frame; the next left slot start commits it
        send_slot(I2S_RIGHT, 24'h000000, 4);
        send_slot(I2S_LEFT,  24'hABCDEF, 31);
        send_slot(I2S_RIGHT, 24'h123456, 31);
        send_slot(I2S_LEFT,  24'h000001, 31);
        wait_clks(2);
        check_frame("basic", 24'hABCDEF, 24'h123456, 32'd1);
        check("basic overrun", {31'd0, overrun}, 32'd0);

        // three frames arrive while the consumer stalls
        send_slot(I2S_RIGHT, 24'h000002, 31);
        send_slot(I2S_LEFT,  24'h000003, 31);
        send_slot(I2S_RIGHT, 24'h000004, 31);
        send_slot(I2S_LEFT,  24'h000005, 31);
        send_slot(I2S_RIGHT, 24'h000006, 31);
        send_slot(I2S_LEFT,  24'h000000, 2);
        wait_clks(2);
        check_frame("stall", 24'hABCDEF, 24'h123456, 32'd1);
        check("stall overrun", {31'd0, overrun}, 32'd1);
        pulse_clr();
        check("ovr clear", {31'd0, overrun}, 32'd0);
        pulse_ready();
        check("consume valid", {31'd0, frame_bus.m_valid}, 32'd0);

        // 16 data bits per slot: low byte is zero-padded
        @(posedge ACLK); #1;
        enable = 1'b0;
        wait_clks(3);
        enable = 1'b1;
        send_slot(I2S_RIGHT, 24'h000000, 4);
        send_slot(I2S_LEFT,  24'hBEEF00, 16);
        send_slot(I2S_RIGHT, 24'hCAFE00, 16);
        send_slot(I2S_LEFT,  24'h000000, 2);
        wait_clks(2);
        check_frame("short", 24'hBEEF00, 24'hCAFE00, 32'd2);
        pulse_ready();

        // reset, then join the stream in the middle of a right slot
        @(posedge ACLK); #2;
        ARESETN = 1'b0;
        #4;
        ARESETN = 1'b1;
        wait_clks(1);
        check("rst2 count", frame_count, 32'd0);
        send_slot(I2S_RIGHT, 24'h5A5A5A, 10);
        send_slot(I2S_LEFT,  24'h13579B, 31);
        send_slot(I2S_RIGHT, 24'h2468AC, 31);
        wait_clks(2);
        check("midjoin no valid", {31'd0, frame_bus.m_valid}, 32'd0);
        send_slot(I2S_LEFT,  24'h000000, 2);
        wait_clks(2);
        check_frame("midjoin", 24'h13579B, 24'h2468AC, 32'd1);
        pulse_ready();

        // drop enable mid right slot for two frames
        send_slot(I2S_RIGHT, 24'h0F0F0F, 12);
        @(posedge ACLK); #1;
        enable = 1'b0;
        send_slot(I2S_LEFT,  24'h111111, 31);
        send_slot(I2S_RIGHT, 24'h222222, 31);
        send_slot(I2S_LEFT,  24'h333333, 31);
        send_slot(I2S_RIGHT, 24'h444444, 31);
        @(posedge ACLK); #1;
        enable = 1'b1;
        send_slot(I2S_LEFT,  24'h555555, 31);
        send_slot(I2S_RIGHT, 24'h666666, 31);
        wait_clks(2);
        check("en no valid", {31'd0, frame_bus.m_valid}, 32'd0);
        check("en held left", {8'd0, frame_bus.m_left}, 32'h0013579B);
        check("en count", frame_count, 32'd1);
        send_slot(I2S_LEFT,  24'h000000, 2);
        wait_clks(2);
        check_frame("reenable", 24'h555555, 24'h666666, 32'd2);

        // asynchronous reset mid left slot while a frame is held
        @(posedge ACLK); #2;
        ARESETN = 1'b0;
        #1;
        check("arst valid", {31'd0, frame_bus.m_valid}, 32'd0);
        check("arst left",  {8'd0, frame_bus.m_left},   32'd0);
        check("arst right", {8'd0, frame_bus.m_right},  32'd0);
        check("arst count", frame_count,                32'd0);
        #3;
        ARESETN = 1'b1;
        send_slot(I2S_LEFT,  24'h000000, 5);
        send_slot(I2S_RIGHT, 24'h999999, 31);
        send_slot(I2S_LEFT,  24'hC0FFEE, 31);
        send_slot(I2S_RIGHT, 24'h00BEAD, 31);
        wait_clks(2);
        check("resume no valid", {31'd0, frame_bus.m_valid}, 32'd0);
        send_slot(I2S_LEFT,  24'h000000, 2);
        wait_clks(2);
        check_frame("resume", 24'hC0FFEE, 24'h00BEAD, 32'd1);
        check("resume overrun", {31'd0, overrun}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
